fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the pipelined RISC-V core: owns the program counter, drives the word index into the combinational instruction memory, and registers the returned instruction into the IF/ID pipeline register for decode. Handles hazard stalls and branch/jump redirects (with flush) from later stages. It sits directly upstream of the instruction memory and directly upstream of decode.

## Interface
- MEM_DEPTH, 256, instruction memory depth in words; power of two; PC wraps modulo this.
- RESET_PC, 0, word index loaded into PC on reset.
- NOP_INSTR, 32'h00000013, instruction (ADDI x0,x0,0) placed in IF/ID on reset or flush.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit request to hold PC and IF/ID
- redirect  in  1  taken branch/jump resolved downstream; flush and load new PC
- redirect_pc  in  32  target word index for redirect
- imem_instr  in  32  instruction returned combinationally by instruction memory
- imem_pc  out  32  word index to instruction memory (= PC register)
- id_instr  out  32  IF/ID registered instruction
- id_pc  out  32  IF/ID registered word index of id_instr
- id_valid  out  1  IF/ID holds a real fetched instruction
- fetch_count  out  32  fetched-instruction counter (FETCH_PERF_CNT_EN only)
- stall_count  out  32  stalled-cycle counter (FETCH_PERF_CNT_EN only)

## Operation
- PC is a word index, not a byte address; increment is +1.
- imem_pc is the PC register directly; no combinational path from any input to imem_pc.
- Per rising edge, priority redirect > stall > advance:
  - redirect=1 (stall ignored): PC <= redirect_pc & (MEM_DEPTH-1); id_instr <= NOP_INSTR, id_pc <= 0, id_valid <= 0.
  - stall=1, redirect=0: PC, id_instr, id_pc, id_valid all hold.
  - otherwise: PC <= (PC+1) & (MEM_DEPTH-1); id_instr <= imem_instr; id_pc <= PC; id_valid <= 1.
- Wrap: PC = MEM_DEPTH-1 advancing goes to 0; id_pc for that fetch = MEM_DEPTH-1.
- Out-of-range redirect_pc truncated to low log2(MEM_DEPTH) bits; upper PC bits always 0.
- Reset (async, any time incl. mid-stall/redirect): PC = RESET_PC & (MEM_DEPTH-1), id_instr = NOP_INSTR, id_pc = 0, id_valid = 0; counters = 0. Effective immediately, not at next edge.

## Timing
- Fetch latency: PC value at cycle N appears on id_instr/id_pc after edge ending cycle N (one cycle).
- After reset release: first edge registers instruction at RESET_PC; id_valid rises after first edge.
- Redirect in cycle N: imem_pc = target in N+1; target instruction in IF/ID after edge ending N+1; exactly one bubble (id_valid=0 during N+1).
- Stall held K cycles: outputs frozen K cycles; advance resumes on first edge with stall=0; no instruction lost or duplicated.
- Simultaneous stall+redirect: redirect taken, stall does not extend it.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_count increments on every advancing edge; stall_count increments on every edge with stall=1, redirect=0; both wrap at 2^32, reset to 0.
- Not defined: fetch_count and stall_count ports absent; no counter logic.

## Test plan
- Reset release, no stall/redirect, imem returns 32'h100+PC: after edges 1..4 id_pc = 0,1,2,3, id_instr = 32'h100..32'h103, id_valid = 1 from edge 1.
- stall=1 for 3 cycles with PC=5: imem_pc stays 5, id_pc stays 4 for 3 cycles; after release id_pc = 5, then 6.
- redirect=1, redirect_pc=40 at PC=10: next cycle imem_pc=40, id_valid=0, id_instr=32'h00000013; following edge id_pc=40, id_valid=1.
- redirect and stall both high, redirect_pc=300 (MEM_DEPTH=256): imem_pc = 44, IF/ID flushed.
- PC=255 advancing: id_pc=255, imem_pc=0; async reset pulsed mid-cycle during stall: outputs reset values before next clock edge; with FETCH_PERF_CNT_EN, 4 fetches + 3 stalls give fetch_count=4, stall_count=3.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register into comb imem, fetched word registered into IF/ID; one-cycle latency.
// Backpressure: stall holds PC and IF/ID; redirect flushes IF/ID (one bubble). Optional counters: FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int          MEM_DEPTH = 256,
    parameter int          RESET_PC  = 0,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [31:0] PC_MASK = 32'(MEM_DEPTH - 1);
    localparam logic [31:0] PC_RST  = 32'(RESET_PC) & PC_MASK;

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        advance;

    // Redirect wins over stall so a resolved branch is never delayed by a hazard.
    assign advance = !redirect && !stall;

    always_comb begin
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        if (redirect) begin
            pc_d       = redirect_pc & PC_MASK;
            id_instr_d = NOP_INSTR;
            id_pc_d    = 32'd0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d       = (pc_q + 32'd1) & PC_MASK;
            id_instr_d = imem_instr;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= PC_RST;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_pc  = pc_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_valid = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, advance};
        stall_cnt_d = stall_cnt_q + {31'd0, (stall && !redirect)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: reference model pushes expected IF/ID contents per edge, popped after the edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] MASK = 32'd255;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_instr;
    logic [31:0] imem_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int total = 0;
    int bad   = 0;

    ifid_t       exp_q[$];
    ifid_t       m_ifid;
    ifid_t       got;
    ifid_t       want;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    fetch_stage #(
        .MEM_DEPTH(256),
        .RESET_PC (0),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_instr (imem_instr),
        .imem_pc    (imem_pc),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_valid   (id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: each word holds 0x100 + its index.
    assign imem_instr = 32'h100 + imem_pc;

    task automatic model_reset();
        m_pc    = 32'd0;
        m_ifid  = '{instr: NOP, pc: 32'd0, valid: 1'b0};
        m_fetch = 32'd0;
        m_stall = 32'd0;
        exp_q.delete();
    endtask

    // Drive one cycle of control, predict the IF/ID result, and step past the edge.
    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (rd) begin
            m_ifid = '{instr: NOP, pc: 32'd0, valid: 1'b0};
            m_pc   = rpc & MASK;
        end else if (st) begin
            m_stall = m_stall + 32'd1;
        end else begin
            m_ifid  = '{instr: 32'h100 + m_pc, pc: m_pc, valid: 1'b1};
            m_pc    = (m_pc + 32'd1) & MASK;
            m_fetch = m_fetch + 32'd1;
        end
        exp_q.push_back(m_ifid);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if ({imem_pc, id_instr, id_pc, id_valid} !== {32'd0, NOP, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got pc=%h instr=%h id_pc=%h v=%b want 0/%h/0/0",
                     imem_pc, id_instr, id_pc, id_valid, NOP);
        end
        reset = 1'b0;
    endtask

    task automatic test_advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            want = exp_q.pop_front();
            got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
            total++;
            if (got !== want || id_pc !== 32'(i) || id_instr !== 32'h100 + 32'(i)) begin
                bad++;
                $display("FAIL advance[%0d] got %h/%h/%b want %h/%h/%b", i,
                         got.instr, got.pc, got.valid, want.instr, want.pc, want.valid);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            want = exp_q.pop_front();
            got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
            total++;
            if (got !== want || imem_pc !== 32'd5 || id_pc !== 32'd4) begin
                bad++;
                $display("FAIL stall_hold[%0d] got imem_pc=%h id_pc=%h want 5/4", i, imem_pc, id_pc);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            want = exp_q.pop_front();
            got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
            total++;
            if (got !== want || id_pc !== 32'(5 + i) || id_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_resume[%0d] got id_pc=%h v=%b want %h/1", i, id_pc, id_valid, 5 + i);
            end
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            void'(exp_q.pop_front());
        end
        total++;
        if (imem_pc !== 32'd10) begin
            bad++;
            $display("FAIL redirect_setup got imem_pc=%h want 0000000a", imem_pc);
        end
        drive(1'b0, 1'b1, 32'd40);
        want = exp_q.pop_front();
        got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
        total++;
        if (got !== want || imem_pc !== 32'd40 || id_instr !== NOP || id_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_flush got imem_pc=%h instr=%h v=%b want 28/%h/0",
                     imem_pc, id_instr, id_valid, NOP);
        end
        drive(1'b0, 1'b0, 32'd0);
        want = exp_q.pop_front();
        got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
        total++;
        if (got !== want || id_pc !== 32'd40 || id_instr !== 32'h128 || id_valid !== 1'b1) begin
            bad++;
            $display("FAIL redirect_target got id_pc=%h instr=%h v=%b want 28/128/1", id_pc, id_instr, id_valid);
        end
    endtask

    task automatic test_redirect_stall();
        drive(1'b1, 1'b1, 32'd300);
        want = exp_q.pop_front();
        got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
        total++;
        if (got !== want || imem_pc !== 32'd44 || id_valid !== 1'b0 || id_instr !== NOP) begin
            bad++;
            $display("FAIL redirect_stall got imem_pc=%h v=%b instr=%h want 2c/0/%h",
                     imem_pc, id_valid, id_instr, NOP);
        end
        drive(1'b0, 1'b0, 32'd0);
        want = exp_q.pop_front();
        got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
        total++;
        if (got !== want || id_pc !== 32'd44) begin
            bad++;
            $display("FAIL redirect_stall_next got id_pc=%h want 2c", id_pc);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 32'd255);
        void'(exp_q.pop_front());
        drive(1'b0, 1'b0, 32'd0);
        want = exp_q.pop_front();
        got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
        total++;
        if (got !== want || id_pc !== 32'd255 || imem_pc !== 32'd0) begin
            bad++;
            $display("FAIL wrap got id_pc=%h imem_pc=%h want ff/0", id_pc, imem_pc);
        end
        drive(1'b0, 1'b0, 32'd0);
        want = exp_q.pop_front();
        got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
        total++;
        if (got !== want || id_pc !== 32'd0 || id_instr !== 32'h100) begin
            bad++;
            $display("FAIL wrap_next got id_pc=%h instr=%h want 0/100", id_pc, id_instr);
        end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({imem_pc, id_instr, id_pc, id_valid} !== {32'd0, NOP, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got pc=%h instr=%h id_pc=%h v=%b want 0/%h/0/0",
                     imem_pc, id_instr, id_pc, id_valid, NOP);
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
            bad++;
            $display("FAIL async_reset_cnt got %0d/%0d want 0/0", fetch_count, stall_count);
        end
`endif
        reset = 1'b0;
        stall = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        exp_q.push_back('{instr: 32'h100, pc: 32'd0, valid: 1'b1});
        m_pc    = 32'd1;
        m_fetch = 32'd1;
        want = exp_q.pop_front();
        got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL post_reset_fetch got %h/%h/%b want %h/%h/%b",
                     got.instr, got.pc, got.valid, want.instr, want.pc, want.valid);
        end
    endtask

    task automatic test_perf();
        reset = 1'b1;
        model_reset();
        #3;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(i >= 4, 1'b0, 32'd0);
            want = exp_q.pop_front();
            got  = '{instr: id_instr, pc: id_pc, valid: id_valid};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL perf_seq[%0d] got %h/%h/%b want %h/%h/%b", i,
                         got.instr, got.pc, got.valid, want.instr, want.pc, want.valid);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (fetch_count !== 32'd4 || fetch_count !== m_fetch) begin
            bad++;
            $display("FAIL fetch_count got %0d want 4", fetch_count);
        end
        total++;
        if (stall_count !== 32'd3 || stall_count !== m_stall) begin
            bad++;
            $display("FAIL stall_count got %0d want 3", stall_count);
        end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_advance();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1);
    end

endmodule
